lake_out_checker: RTL and testbench
===================================

# lake_out_checker

Self-checking stream monitor that sits directly downstream of the LakeWrapper memory tile and consumes its two output lanes (data_out_0/1 qualified by valid_out[1:0]). It compares every valid output word against an expected incrementing ramp (the same ramp the bench drives into data_in_0) and accumulates match/error statistics. It captures the first mismatch and raises done/pass after a programmed number of samples. It is synthesizable so the same check runs in RTL simulation, gate-level/power runs and FPGA bring-up.

## Interface
- DATA_WIDTH, 16, width of each data lane
- CNT_WIDTH, 32, width of sample/error counters
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  one-cycle pulse: arm the checker
- cfg_sync_first  in  1  1: first valid word seeds the expectation; 0: use cfg_init
- cfg_init  in  DATA_WIDTH  initial expected value when cfg_sync_first=0
- cfg_num_samples  in  CNT_WIDTH  samples to check before done; 0 means run forever
- flush  in  1  synchronous clear of statistics, returns to ARMED
- data_out_0  in  DATA_WIDTH  lane 0 data from tile
- data_out_1  in  DATA_WIDTH  lane 1 data from tile
- valid_out  in  2  per-lane valid from tile (bit0 lane 0, bit1 lane 1)
- armed  out  1  state is ARMED or CHECKING
- done  out  1  cfg_num_samples consumed
- pass  out  1  done && err_cnt==0
- sample_cnt  out  CNT_WIDTH  samples consumed
- err_cnt  out  CNT_WIDTH  mismatches, saturating
- err_first_idx  out  CNT_WIDTH  sample index of first mismatch
- err_first_exp  out  DATA_WIDTH  expected value at first mismatch
- err_first_got  out  DATA_WIDTH  received value at first mismatch
- err_seen  out  1  at least one mismatch since arm

## Operation
- States: IDLE, ARMED, CHECKING, DONE. Reset -> IDLE.
- IDLE: ignore valid_out. cfg_start -> ARMED. Clears all counters and capture registers. Loads exp<=cfg_init.
- ARMED: wait for first valid lane.
  - cfg_sync_first=1: that word becomes exp and counts as a match.
  - cfg_sync_first=0: compare against cfg_init.
  - -> CHECKING on the same edge.
- CHECKING: each cycle, lanes are consumed in order lane 0 then lane 1.
  - Each valid lane is one sample, compared to the current running expectation.
  - Both valid: lane 0 vs exp, lane 1 vs exp+1.
  - Only lane 1 valid: lane 1 vs exp.
- exp advances by the number of lanes consumed, modulo 2^DATA_WIDTH. 0xFFFF -> 0x0000 is not an error.
- Mismatch handling: err_cnt+1, saturating at all-ones.
  - On the first mismatch, set err_seen and capture idx/exp/got.
  - Both lanes mismatching in the same cycle: capture lane 0.
- Sample limit: when sample_cnt reaches cfg_num_samples (nonzero) -> DONE.
  - If only one sample remains and both lanes are valid, consume lane 0 only; lane 1 is ignored.
- DONE: valid_out ignored. Statistics hold. cfg_start re-arms (-> ARMED with cleared stats).
- flush in any non-IDLE state: clear statistics and exp as on cfg_start, -> ARMED. flush has priority over data in the same cycle.
- cfg_start while CHECKING: restart, same as flush.
- sample_cnt saturates at all-ones when cfg_num_samples=0.

## Timing
- All outputs registered. Reset values: all counters/capture 0; armed, done, pass, err_seen 0.
- Sample on edge N is reflected in sample_cnt/err_cnt/capture after edge N (visible cycle N+1).
- done rises in the cycle after the last sample edge. pass is valid the same cycle as done.
- armed rises the cycle after cfg_start.
- Async rst_n assertion mid-run clears all state immediately. Deassertion is synchronized internally (2-flop) before the FSM leaves IDLE.
- No backpressure: the checker always accepts every valid lane.

## Test plan
- Ramp, sync_first=1, num_samples=100, lane 0 only, values 7..106 -> done after 100 samples, err_cnt=0, pass=1, sample_cnt=100.
- sync_first=0, init=0, both lanes valid with (0,1),(2,3)…, num_samples=10 -> done after 5 cycles, pass=1.
- Inject 0x55 where 20 expected at index 20, then continue correctly -> err_cnt=1, err_first_idx=20, exp=20, got=0x55, pass=0.
- Wrap: init=0xFFFE, lane 0 stream FFFE,FFFF,0000,0001 -> err_cnt=0. Same run with num_samples=3 and both lanes valid on the last cycle -> lane 1 ignored, sample_cnt=3.
- rst_n low for 3 cycles mid-CHECKING -> all outputs 0, state IDLE, no arming until cfg_start. flush mid-run with valid data that cycle -> stats 0, data not counted, armed=1.
- num_samples=0, 70000 samples with 16-bit wrap -> never done, err_cnt=0, sample_cnt=70000.

Source files
------------

// File: rtl/lake_out_checker.sv
// lake_out_checker: checks the two tile output lanes against an incrementing ramp and keeps match/error statistics.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset (release synchronized internally)
//   cfg_start               pulse: arm or restart the checker
//   cfg_sync_first          1: first valid word seeds the expectation, 0: start from cfg_init
//   cfg_init                initial expected value
//   cfg_num_samples         samples to check before done, 0 = run forever
//   flush                   clear statistics and return to ARMED (ignored in IDLE)
//   data_out_0/1, valid_out tile output lanes, lane 0 consumed before lane 1
//   armed, done, pass       status flags
//   sample_cnt, err_cnt     consumed samples and mismatches, both saturating
//   err_first_idx/exp/got   capture of the first mismatch
//   err_seen                at least one mismatch since arm
module lake_out_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_sync_first,
    input  logic [DATA_WIDTH-1:0] cfg_init,
    input  logic [CNT_WIDTH-1:0]  cfg_num_samples,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_out_0,
    input  logic [DATA_WIDTH-1:0] data_out_1,
    input  logic [1:0]            valid_out,
    output logic                  armed,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_WIDTH-1:0]  sample_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  err_first_idx,
    output logic [DATA_WIDTH-1:0] err_first_exp,
    output logic [DATA_WIDTH-1:0] err_first_got,
    output logic                  err_seen
);

    typedef enum logic [1:0] {IDLE, ARMED, CHECKING, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            rsync_q;
    logic                  rst_ok;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, err_q, err_d, idx_q, idx_d;
    logic [DATA_WIDTH-1:0] fexp_q, fexp_d, fgot_q, fgot_d;
    logic                  seen_q, seen_d;
    logic                  armed_q, armed_d, done_q, done_d, pass_q, pass_d;

    logic                  clr, live, last_one, u0, u1, m0, m1, reached;
    logic [DATA_WIDTH-1:0] base, exp1;
    logic [CNT_WIDTH:0]    cnt_sum, err_sum;
    logic [CNT_WIDTH-1:0]  cnt_nxt, err_nxt;

    // The FSM is held in IDLE until reset release has passed two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsync_q <= 2'b00;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end

    assign rst_ok = rsync_q[1];

    // A restart (cfg_start anywhere, flush outside IDLE) overrides any data in the same cycle.
    assign clr  = rst_ok && (cfg_start || (flush && state_q != IDLE));
    assign live = rst_ok && !clr && (state_q == ARMED || state_q == CHECKING);

    // In ARMED with sync_first the first valid word becomes the expectation, so it always matches.
    assign base     = (state_q == ARMED && cfg_sync_first) ? (valid_out[0] ? data_out_0 : data_out_1) : exp_q;
    assign last_one = (cfg_num_samples != '0) && (cnt_q + CNT_WIDTH'(1) == cfg_num_samples);
    assign u0       = live && valid_out[0];
    // With one sample left and both lanes valid, lane 1 is dropped.
    assign u1       = live && valid_out[1] && !(u0 && last_one);
    assign exp1     = base + DATA_WIDTH'(u0);
    assign m0       = u0 && (data_out_0 != base);
    assign m1       = u1 && (data_out_1 != exp1);

    assign cnt_sum  = {1'b0, cnt_q} + (CNT_WIDTH+1)'(u0) + (CNT_WIDTH+1)'(u1);
    assign err_sum  = {1'b0, err_q} + (CNT_WIDTH+1)'(m0) + (CNT_WIDTH+1)'(m1);
    assign cnt_nxt  = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    assign err_nxt  = err_sum[CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
    assign reached  = (cfg_num_samples != '0) && (cnt_nxt >= cfg_num_samples);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!rst_ok)               state_d = IDLE;
        else if (clr)              state_d = ARMED;
        else if (live && (u0 || u1)) state_d = reached ? DONE : CHECKING;
    end

    always_comb begin
        exp_d  = exp_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        idx_d  = idx_q;
        fexp_d = fexp_q;
        fgot_d = fgot_q;
        seen_d = seen_q;
        if (clr) begin
            exp_d  = cfg_init;
            cnt_d  = '0;
            err_d  = '0;
            idx_d  = '0;
            fexp_d = '0;
            fgot_d = '0;
            seen_d = 1'b0;
        end else if (live) begin
            exp_d = exp1 + DATA_WIDTH'(u1);
            cnt_d = cnt_nxt;
            err_d = err_nxt;
            if (!seen_q && (m0 || m1)) begin
                seen_d = 1'b1;
                idx_d  = m0 ? cnt_q : cnt_q + CNT_WIDTH'(u0);
                fexp_d = m0 ? base : exp1;
                fgot_d = m0 ? data_out_0 : data_out_1;
            end
        end
    end

    always_comb begin
        armed_d = (state_d == ARMED) || (state_d == CHECKING);
        done_d  = (state_d == DONE);
        pass_d  = done_d && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
            seen_q  <= 1'b0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            fexp_q  <= fexp_d;
            fgot_q  <= fgot_d;
            seen_q  <= seen_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign armed         = armed_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign sample_cnt    = cnt_q;
    assign err_cnt       = err_q;
    assign err_first_idx = idx_q;
    assign err_first_exp = fexp_q;
    assign err_first_got = fgot_q;
    assign err_seen      = seen_q;

endmodule

// File: tb/tb_lake_out_checker.sv
// tb_lake_out_checker: directed table-driven and sequence checks of lake_out_checker.
module tb_lake_out_checker;

    logic        clk = 1'b0;
    logic        rst_n, cfg_start, cfg_sync_first, flush;
    logic [15:0] cfg_init, data_out_0, data_out_1;
    logic [31:0] cfg_num_samples;
    logic [1:0]  valid_out;
    logic        armed, done, pass, err_seen;
    logic [31:0] sample_cnt, err_cnt, err_first_idx;
    logic [15:0] err_first_exp, err_first_got;

    int total = 0;
    int passed = 0;

    lake_out_checker #(.DATA_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_sync_first(cfg_sync_first),
        .cfg_init(cfg_init), .cfg_num_samples(cfg_num_samples), .flush(flush),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .valid_out(valid_out),
        .armed(armed), .done(done), .pass(pass), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .err_first_idx(err_first_idx), .err_first_exp(err_first_exp),
        .err_first_got(err_first_got), .err_seen(err_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, fl;
        logic [1:0]  v;
        logic [15:0] d0, d1;
        logic        e_armed, e_done, e_pass;
        logic [31:0] e_cnt, e_err;
        logic        e_seen;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic s, logic f, logic [1:0] v, logic [15:0] d0, logic [15:0] d1,
                                logic a, logic dn, logic p, logic [31:0] c, logic [31:0] e, logic sn);
        vec_t r;
        r.start = s; r.fl = f; r.v = v; r.d0 = d0; r.d1 = d1;
        r.e_armed = a; r.e_done = dn; r.e_pass = p; r.e_cnt = c; r.e_err = e; r.e_seen = sn;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic sync, input logic [15:0] init, input logic [31:0] num);
        cfg_sync_first = sync; cfg_init = init; cfg_num_samples = num;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("armed_after_start", armed, 1);
    endtask

    task automatic send(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1);
        valid_out = v; data_out_0 = d0; data_out_1 = d1;
        step();
        valid_out = 2'b00;
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_sync_first = 1'b0; flush = 1'b0;
        cfg_init = '0; cfg_num_samples = '0; data_out_0 = '0; data_out_1 = '0; valid_out = '0;
        repeat (3) step();
        chk("reset_armed", armed, 0);
        chk("reset_done", done, 0);
        chk("reset_cnt", sample_cnt, 0);
        rst_n = 1'b1;
        repeat (3) step();

        // both lanes, init 0, 10 samples, then restart / error / flush / lane-1-only rows
        tbl[0]  = mk(1, 0, 2'b00, 0,  0,  1, 0, 0, 0,  0, 0);
        tbl[1]  = mk(0, 0, 2'b11, 0,  1,  1, 0, 0, 2,  0, 0);
        tbl[2]  = mk(0, 0, 2'b11, 2,  3,  1, 0, 0, 4,  0, 0);
        tbl[3]  = mk(0, 0, 2'b11, 4,  5,  1, 0, 0, 6,  0, 0);
        tbl[4]  = mk(0, 0, 2'b11, 6,  7,  1, 0, 0, 8,  0, 0);
        tbl[5]  = mk(0, 0, 2'b11, 8,  9,  0, 1, 1, 10, 0, 0);
        tbl[6]  = mk(0, 0, 2'b11, 10, 11, 0, 1, 1, 10, 0, 0);
        tbl[7]  = mk(1, 0, 2'b00, 0,  0,  1, 0, 0, 0,  0, 0);
        tbl[8]  = mk(0, 0, 2'b01, 5,  0,  1, 0, 0, 1,  1, 1);
        tbl[9]  = mk(0, 1, 2'b01, 1,  0,  1, 0, 0, 0,  0, 0);
        tbl[10] = mk(0, 0, 2'b10, 0,  0,  1, 0, 0, 1,  0, 0);
        tbl[11] = mk(0, 0, 2'b11, 1,  7,  1, 0, 0, 3,  1, 1);
        cfg_sync_first = 1'b0; cfg_init = 16'h0; cfg_num_samples = 32'd10;
        for (int i = 0; i < 12; i++) begin
            cfg_start = tbl[i].start; flush = tbl[i].fl;
            valid_out = tbl[i].v; data_out_0 = tbl[i].d0; data_out_1 = tbl[i].d1;
            step();
            chk($sformatf("tbl%0d_armed", i), armed, tbl[i].e_armed);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("tbl%0d_pass", i), pass, tbl[i].e_pass);
            chk($sformatf("tbl%0d_cnt", i), sample_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].e_err);
            chk($sformatf("tbl%0d_seen", i), err_seen, tbl[i].e_seen);
        end
        cfg_start = 1'b0; flush = 1'b0; valid_out = 2'b00;
        chk("tbl_first_idx", err_first_idx, 2);
        chk("tbl_first_exp", err_first_exp, 2);
        chk("tbl_first_got", err_first_got, 7);

        // ramp 7..106 on lane 0, seeded by the first word
        arm(1, 16'h1234, 100);
        send(2'b01, 16'd7, 0);
        chk("ramp_seed_cnt", sample_cnt, 1);
        chk("ramp_seed_err", err_cnt, 0);
        for (int i = 8; i <= 105; i++) send(2'b01, 16'(i), 0);
        chk("ramp_not_done_99", done, 0);
        send(2'b01, 16'd106, 0);
        chk("ramp_done", done, 1);
        chk("ramp_pass", pass, 1);
        chk("ramp_cnt", sample_cnt, 100);
        chk("ramp_err", err_cnt, 0);
        chk("ramp_armed_low", armed, 0);

        // single injected error at index 20
        arm(0, 16'h0, 40);
        for (int i = 0; i < 40; i++) send(2'b01, (i == 20) ? 16'h55 : 16'(i), 0);
        chk("inj_err", err_cnt, 1);
        chk("inj_idx", err_first_idx, 20);
        chk("inj_exp", err_first_exp, 20);
        chk("inj_got", err_first_got, 16'h55);
        chk("inj_seen", err_seen, 1);
        chk("inj_done", done, 1);
        chk("inj_pass", pass, 0);

        // wrap through 0xFFFF
        arm(0, 16'hFFFE, 0);
        send(2'b01, 16'hFFFE, 0);
        send(2'b01, 16'hFFFF, 0);
        send(2'b01, 16'h0000, 0);
        send(2'b01, 16'h0001, 0);
        chk("wrap_err", err_cnt, 0);
        chk("wrap_cnt", sample_cnt, 4);
        chk("wrap_done", done, 0);

        // last sample with both lanes valid: lane 1 dropped
        arm(0, 16'hFFFE, 3);
        send(2'b01, 16'hFFFE, 0);
        send(2'b01, 16'hFFFF, 0);
        send(2'b11, 16'h0000, 16'h1234);
        chk("lim_cnt", sample_cnt, 3);
        chk("lim_err", err_cnt, 0);
        chk("lim_done", done, 1);
        chk("lim_pass", pass, 1);

        // async reset mid-run, then synchronized release
        arm(0, 16'h0, 0);
        send(2'b01, 0, 0);
        send(2'b01, 1, 0);
        send(2'b01, 2, 0);
        chk("prerst_cnt", sample_cnt, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_async_cnt", sample_cnt, 0);
        chk("rst_async_armed", armed, 0);
        repeat (3) step();
        rst_n = 1'b1;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        chk("rst_sync_ignore_start", armed, 0);
        send(2'b01, 3, 0);
        send(2'b01, 4, 0);
        chk("rst_idle_armed", armed, 0);
        chk("rst_idle_cnt", sample_cnt, 0);
        chk("rst_idle_err", err_cnt, 0);

        // run forever: 70000 samples over both lanes
        arm(0, 16'h0, 0);
        saw_done = 1'b0;
        for (int k = 0; k < 35000; k++) begin
            send(2'b11, 16'(2 * k), 16'(2 * k + 1));
            saw_done = saw_done | done;
        end
        chk("forever_done_never", saw_done, 0);
        chk("forever_cnt", sample_cnt, 70000);
        chk("forever_err", err_cnt, 0);
        chk("forever_armed", armed, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
